stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
Timekeeping core of the lab3 stopwatch. It sits directly downstream of the clock-generation stage and consumes that stage's 1 Hz and 2 Hz rates as single-cycle enables in the clk domain. It maintains an MM:SS value as four BCD digits, with run/pause control and an adjust mode. Digits feed the seven-segment display stage, which uses adj_active together with the blink rate to flash the selected field.

Parameters:
SEC_WRAP, 60, seconds field modulus; legal range 2..100; counts 0..SEC_WRAP-1
MIN_WRAP, 60, minutes field modulus; legal range 2..100; counts 0..MIN_WRAP-1

Ports:
clk  input  1  100 MHz system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-clk-wide enable at 1 Hz from clock stage
tick_2hz  input  1  one-clk-wide enable at 2 Hz from clock stage
pause_pulse  input  1  debounced, one-clk-wide pulse; toggles run/pause
adj  input  1  level; 1 = adjust mode
sel  input  1  level; adjust target, 0 = minutes, 1 = seconds
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit
sec_ones  output  4  BCD seconds ones digit
running  output  1  1 when state is RUN
adj_active  output  1  registered copy of adj
rollover  output  1  one-clk pulse on wrap from max:max to 00:00 in normal mode

Behaviour:
- Reset (async assert, sync-free release): all digits 0, state RUN, running=1, adj_active=0, rollover=0.
- Two-state FSM:
  - RUN: a pause_pulse moves to PAUSED.
  - PAUSED: a pause_pulse moves to RUN.
  - pause_pulse toggles the state regardless of adj.
- Normal mode (adj=0):
  - Seconds increment on tick_1hz only when the FSM is in RUN in that cycle, i.e. before any toggle in the same cycle.
  - If pause_pulse and tick_1hz coincide while in RUN, the tick is counted and the state becomes PAUSED.
  - If they coincide while in PAUSED, the tick is ignored and the state becomes RUN.
- Seconds carry: at SEC_WRAP-1, a tick sets seconds to 0 and increments minutes in the same cycle.
- Minutes wrap: at MIN_WRAP-1 with a seconds carry, minutes go to 0. rollover=1 for exactly that cycle only when both fields wrap.
- Adjust mode (adj=1):
  - tick_1hz is ignored.
  - tick_2hz increments only the field chosen by sel; the other field holds.
  - The adjusted field wraps modulo its own WRAP with no carry into minutes and no rollover pulse.
  - Adjust operates in both RUN and PAUSED; the FSM state is preserved across adj changes.
- Mode change: adj/sel are sampled each cycle, with no synchronizer (the inputs are already synchronized upstream). A change takes effect on the next tick after the cycle in which it is sampled.
- Latency: outputs are registered and update on the clk edge where the enable is sampled, so they are visible one cycle after the tick is high.
- BCD arithmetic:
  - ones digit 9 rolls to 0 and increments tens.
  - The field value is tens*10+ones; wrap compares against WRAP-1.
  - Digits never exceed 9; tens never exceeds (WRAP-1)/10.
- Reset mid-count clears all digits immediately, without waiting for a clock edge.

Decomposition:
- Shared package stopwatch_pkg:
  - BCD_W=4.
  - FSM state encoding ST_RUN/ST_PAUSED.
  - Default wrap constants SEC_WRAP_DEF=60, MIN_WRAP_DEF=60.
- Sub-module bcd_mod_counter, instantiated twice (seconds, minutes):
  - Ports: clk, rst, inc, tens, ones, at_max (combinational).
  - Parameter WRAP.
  - The top level generates the inc enables, the carry and rollover.

Test Plan:
- Reset then 75 tick_1hz pulses, adj=0 -> digits 01:15, running=1, rollover never asserted.
- Preload to 59:58 via adjust, then adj=0 and 2 tick_1hz -> 59:59 then 00:00; rollover high exactly one cycle on the second tick.
- In RUN at 00:05, pause_pulse and tick_1hz in the same cycle -> 00:06 and running=0; 3 further ticks -> still 00:06; pause_pulse coincident with a tick -> 00:06, running=1.
- adj=1, sel=1 at 00:58, 3 tick_2hz -> 00:01 with minutes still 00; tick_1hz pulses during this window -> no effect.
- adj=1, sel=0 at 58:30, 2 tick_2hz -> 00:30; no rollover pulse.
- Assert rst asynchronously mid-cycle at 12:34 while PAUSED -> digits 00:00 before the next clk edge; running=1 after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

    localparam int unsigned BCD_W        = 4;
    localparam int unsigned SEC_WRAP_DEF = 60;
    localparam int unsigned MIN_WRAP_DEF = 60;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo WRAP; at_max flags the WRAP-1 value combinationally.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned WRAP = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             at_max
);

    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'((WRAP - 1) / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'((WRAP - 1) % 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign tens   = tens_q;
    assign ones   = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == NINE) begin
                tens_d = tens_q + BCD_W'(1);
                ones_d = '0;
            end else begin
                ones_d = ones_q + BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: run/pause FSM, normal counting with carry, and per-field adjust.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_WRAP = SEC_WRAP_DEF,
    parameter int unsigned MIN_WRAP = MIN_WRAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             pause_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             adj_active,
    output logic             rollover
);

    state_e state_q, state_d;
    logic   adj_q, adj_d;
    logic   sel_q, sel_d;
    logic   rollover_q, rollover_d;

    logic   norm_tick_c;
    logic   sec_inc_c;
    logic   min_inc_c;
    logic   sec_at_max_c;
    logic   min_at_max_c;

    // Mode decisions use the registered adj/sel, so a change applies from the following tick.
    always_comb begin
        state_d     = state_q;
        adj_d       = adj;
        sel_d       = sel;
        rollover_d  = 1'b0;
        norm_tick_c = !adj_q && tick_1hz && (state_q == ST_RUN);
        sec_inc_c   = norm_tick_c || (adj_q && tick_2hz && sel_q);
        min_inc_c   = (norm_tick_c && sec_at_max_c) || (adj_q && tick_2hz && !sel_q);

        if (norm_tick_c && sec_at_max_c && min_at_max_c) begin
            rollover_d = 1'b1;
        end

        case (state_q)
            ST_RUN:    if (pause_pulse) state_d = ST_PAUSED;
            ST_PAUSED: if (pause_pulse) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            adj_q      <= 1'b0;
            sel_q      <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adj_q      <= adj_d;
            sel_q      <= sel_d;
            rollover_q <= rollover_d;
        end
    end

    bcd_mod_counter #(.WRAP(SEC_WRAP)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .inc    (sec_inc_c),
        .tens   (sec_tens),
        .ones   (sec_ones),
        .at_max (sec_at_max_c)
    );

    bcd_mod_counter #(.WRAP(MIN_WRAP)) u_min (
        .clk    (clk),
        .rst    (rst),
        .inc    (min_inc_c),
        .tens   (min_tens),
        .ones   (min_ones),
        .at_max (min_at_max_c)
    );

    assign running    = (state_q == ST_RUN);
    assign adj_active = adj_q;
    assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: vector table, directed corners, random vs. model.
module tb_stopwatch_counter;

    localparam int unsigned SW = 60;
    localparam int unsigned MW = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_2hz, pause_pulse, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, adj_active, rollover;

    int checks = 0;
    int errors = 0;

    // reference model: field values as plain integers
    int m_sec, m_min;
    bit m_run, m_adj, m_sel, m_roll;

    typedef struct {
        bit t1, t2, p, a, s;
        int e_min, e_sec;
        bit e_run, e_adj, e_roll;
    } vec_t;

    vec_t vecs[21];

    stopwatch_counter #(.SEC_WRAP(SW), .MIN_WRAP(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .adj_active  (adj_active),
        .rollover    (rollover)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_run = 1'b1; m_adj = 1'b0; m_sel = 1'b0; m_roll = 1'b0;
    endtask

    task automatic model_step();
        m_roll = 1'b0;
        if (!m_adj) begin
            if (tick_1hz && m_run) begin
                m_sec++;
                if (m_sec == SW) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min == MW) begin
                        m_min  = 0;
                        m_roll = 1'b1;
                    end
                end
            end
        end else if (tick_2hz) begin
            if (m_sel) m_sec = (m_sec + 1) % SW;
            else       m_min = (m_min + 1) % MW;
        end
        if (pause_pulse) m_run = !m_run;
        m_adj = adj;
        m_sel = sel;
    endtask

    task automatic check_all();
        check("min_tens",   int'(min_tens),   m_min / 10);
        check("min_ones",   int'(min_ones),   m_min % 10);
        check("sec_tens",   int'(sec_tens),   m_sec / 10);
        check("sec_ones",   int'(sec_ones),   m_sec % 10);
        check("running",    int'(running),    int'(m_run));
        check("adj_active", int'(adj_active), int'(m_adj));
        check("rollover",   int'(rollover),   int'(m_roll));
    endtask

    // one clock with the given inputs; pulses drop afterwards, levels persist
    task automatic cyc(input bit t1, input bit t2, input bit p, input bit a, input bit s);
        tick_1hz = t1; tick_2hz = t2; pause_pulse = p; adj = a; sel = s;
        @(posedge clk);
        model_step();
        #1;
        tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pulse = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic check_time(input string name, input int mm, input int ss);
        check({name, "_min"}, int'(min_tens) * 10 + int'(min_ones), mm);
        check({name, "_sec"}, int'(sec_tens) * 10 + int'(sec_ones), ss);
    endtask

    // load MM:SS through adjust mode, leaving adj=0 and the mode settled
    task automatic preload(input int mm, input int ss);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < mm; i++) cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < ss; i++) cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit saw_roll;
        bit a_lvl, s_lvl;

        vecs[0]  = '{1,0,0,0,0, 0, 1, 1,0,0};
        vecs[1]  = '{1,0,0,0,0, 0, 2, 1,0,0};
        vecs[2]  = '{1,0,0,0,0, 0, 3, 1,0,0};
        vecs[3]  = '{1,0,0,0,0, 0, 4, 1,0,0};
        vecs[4]  = '{1,0,0,0,0, 0, 5, 1,0,0};
        vecs[5]  = '{1,0,1,0,0, 0, 6, 0,0,0};  // tick counted, then pause
        vecs[6]  = '{1,0,0,0,0, 0, 6, 0,0,0};
        vecs[7]  = '{1,0,0,0,0, 0, 6, 0,0,0};
        vecs[8]  = '{1,0,0,0,0, 0, 6, 0,0,0};
        vecs[9]  = '{1,0,1,0,0, 0, 6, 1,0,0};  // tick ignored, resume
        vecs[10] = '{1,0,0,0,0, 0, 7, 1,0,0};
        vecs[11] = '{0,0,0,1,0, 0, 7, 1,1,0};
        vecs[12] = '{1,0,0,1,0, 0, 7, 1,1,0};
        vecs[13] = '{0,0,0,1,1, 0, 7, 1,1,0};
        vecs[14] = '{0,1,0,1,1, 0, 8, 1,1,0};
        vecs[15] = '{1,1,0,1,1, 0, 9, 1,1,0};
        vecs[16] = '{0,0,1,1,0, 0, 9, 0,1,0};
        vecs[17] = '{0,1,0,1,0, 1, 9, 0,1,0};  // adjust while paused
        vecs[18] = '{1,0,0,0,0, 1, 9, 0,0,0};  // registered adj still 1 here
        vecs[19] = '{0,0,1,0,0, 1, 9, 1,0,0};
        vecs[20] = '{1,0,0,0,0, 1,10, 1,0,0};

        rst = 1'b1;
        tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;
        model_reset();
        #12;
        check_all();
        check_time("reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 75 seconds of normal counting
        saw_roll = 1'b0;
        for (int i = 0; i < 75; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (rollover) saw_roll = 1'b1;
            cyc(0, 0, 0, 0, 0);
            if (rollover) saw_roll = 1'b1;
        end
        check_time("count75", 1, 15);
        check("count75_running", int'(running), 1);
        check("count75_noroll", int'(saw_roll), 0);

        // vector table from a fresh reset
        do_reset();
        foreach (vecs[i]) begin
            cyc(vecs[i].t1, vecs[i].t2, vecs[i].p, vecs[i].a, vecs[i].s);
            check($sformatf("vec%0d_time", i),
                  (int'(min_tens) * 10 + int'(min_ones)) * 100 + int'(sec_tens) * 10 + int'(sec_ones),
                  vecs[i].e_min * 100 + vecs[i].e_sec);
            check($sformatf("vec%0d_run", i),  int'(running),    int'(vecs[i].e_run));
            check($sformatf("vec%0d_adj", i),  int'(adj_active), int'(vecs[i].e_adj));
            check($sformatf("vec%0d_roll", i), int'(rollover),   int'(vecs[i].e_roll));
        end

        // full rollover from 59:58
        do_reset();
        preload(59, 58);
        check_time("pre5958", 59, 58);
        cyc(1, 0, 0, 0, 0);
        check_time("t5959", 59, 59);
        check("t5959_roll", int'(rollover), 0);
        cyc(1, 0, 0, 0, 0);
        check_time("t0000", 0, 0);
        check("t0000_roll", int'(rollover), 1);
        cyc(0, 0, 0, 0, 0);
        check("roll_one_cycle", int'(rollover), 0);

        // seconds adjust wraps without carry; 1 Hz ignored in adjust
        do_reset();
        for (int i = 0; i < 58; i++) cyc(1, 0, 0, 0, 0);
        check_time("pre0058", 0, 58);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1);
        check_time("adj_sec", 0, 1);

        // minutes adjust wraps with no rollover
        do_reset();
        preload(58, 30);
        cyc(0, 0, 0, 1, 0);
        saw_roll = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 1, 0);
            if (rollover) saw_roll = 1'b1;
        end
        check_time("adj_min", 0, 30);
        check("adj_min_noroll", int'(saw_roll), 0);

        // async reset while paused at 12:34
        do_reset();
        preload(12, 34);
        cyc(0, 0, 1, 0, 0);
        check_time("pre1234", 12, 34);
        check("pre1234_paused", int'(running), 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_time("async_rst", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("after_rst_running", int'(running), 1);

        // randomized run against the model
        a_lvl = 1'b0;
        s_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) a_lvl = !a_lvl;
            if ($urandom_range(0, 7) == 0)  s_lvl = !s_lvl;
            cyc($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, a_lvl, s_lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
